// File: rtl/fpu_host_ctrl.sv
// Bus initiator that writes operands/opcode to the FPU byte bus, waits for cmd_end,
// reads the 32-bit result back and completes the end_ack handshake.
// Optional watchdog in WAIT_END/ACK: define FPU_HOST_TIMEOUT_EN.
module fpu_host_ctrl #(
  parameter int unsigned STROBE_CYCLES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [7:0]  opcode,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic        fpu_cs,
  output logic        fpu_rd,
  output logic        fpu_wr,
  output logic [3:0]  fpu_addr,
  output logic [7:0]  fpu_dout,
  input  logic [7:0]  fpu_din,
  input  logic        fpu_cmd_end,
  output logic        fpu_end_ack
);

  typedef enum logic [3:0] {
    StIdle, StWSetup, StWStrobe, StWHold, StWaitEnd,
    StRSetup, StRStrobe, StRHold, StAck, StFin
  } state_e;

  state_e      r_state;
  logic        r_ready, r_done, r_err, r_cs, r_rd, r_wr, r_end_ack;
  logic [31:0] r_result, r_shadow, r_opa, r_opb;
  logic [7:0]  r_opc, r_dout;
  logic [3:0]  r_addr, r_idx, r_cnt;

  logic [3:0]  w_next_idx;
  logic [7:0]  w_wbyte;
  logic [1:0]  w_rsel;
  logic        w_strobe_last;
  logic        w_tmo_hit;

`ifdef FPU_HOST_TIMEOUT_EN
  logic [15:0] r_tmo;

  // Free-runs only in WAIT_END/ACK; every path into those states passes a clearing state.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_tmo <= 16'd0;
    end else if (r_state == StWaitEnd || r_state == StAck) begin
      r_tmo <= r_tmo + 16'd1;
    end else begin
      r_tmo <= 16'd0;
    end
  end

  assign w_tmo_hit = (r_state == StWaitEnd || r_state == StAck) &&
                     (r_tmo == 16'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_tmo_hit    = 1'b0;
`endif

  assign w_next_idx    = r_idx + 4'd1;
  // Result bytes live at 9..12; low two index bits minus one give byte lanes 0..3.
  assign w_rsel        = r_idx[1:0] - 2'd1;
  assign w_strobe_last = (r_cnt == 4'(STROBE_CYCLES - 1));

  always_comb begin
    w_wbyte = r_opa[7:0];
    case (w_next_idx)
      4'd1:    w_wbyte = r_opa[15:8];
      4'd2:    w_wbyte = r_opa[23:16];
      4'd3:    w_wbyte = r_opa[31:24];
      4'd4:    w_wbyte = r_opb[7:0];
      4'd5:    w_wbyte = r_opb[15:8];
      4'd6:    w_wbyte = r_opb[23:16];
      4'd7:    w_wbyte = r_opb[31:24];
      4'd8:    w_wbyte = r_opc;
      default: w_wbyte = r_opa[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= StIdle;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_result  <= 32'd0;
      r_shadow  <= 32'd0;
      r_cs      <= 1'b1;
      r_rd      <= 1'b1;
      r_wr      <= 1'b1;
      r_end_ack <= 1'b0;
      r_addr    <= 4'd0;
      r_dout    <= 8'd0;
      r_idx     <= 4'd0;
      r_cnt     <= 4'd0;
      r_opa     <= 32'd0;
      r_opb     <= 32'd0;
      r_opc     <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_opa   <= op_a;
            r_opb   <= op_b;
            r_opc   <= opcode;
            r_ready <= 1'b0;
            r_idx   <= 4'd0;
            r_addr  <= 4'd0;
            r_dout  <= op_a[7:0];
            r_cs    <= 1'b0;
            r_state <= StWSetup;
          end
        end
        StWSetup: begin
          r_wr    <= 1'b0;
          r_cnt   <= 4'd0;
          r_state <= StWStrobe;
        end
        StWStrobe: begin
          if (w_strobe_last) begin
            r_wr    <= 1'b1;
            r_state <= StWHold;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StWHold: begin
          if (r_idx == 4'd8) begin
            r_cs    <= 1'b1;
            r_state <= StWaitEnd;
          end else begin
            r_idx   <= w_next_idx;
            r_addr  <= w_next_idx;
            r_dout  <= w_wbyte;
            r_state <= StWSetup;
          end
        end
        StWaitEnd: begin
          if (w_tmo_hit) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= StFin;
          end else if (fpu_cmd_end) begin
            r_idx   <= 4'd9;
            r_addr  <= 4'd9;
            r_cs    <= 1'b0;
            r_state <= StRSetup;
          end
        end
        StRSetup: begin
          r_rd    <= 1'b0;
          r_cnt   <= 4'd0;
          r_state <= StRStrobe;
        end
        StRStrobe: begin
          if (w_strobe_last) begin
            r_rd                          <= 1'b1;
            r_shadow[{w_rsel, 3'b000} +: 8] <= fpu_din;
            r_state                       <= StRHold;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StRHold: begin
          if (r_idx == 4'd12) begin
            r_cs      <= 1'b1;
            r_end_ack <= 1'b1;
            r_state   <= StAck;
          end else begin
            r_idx   <= w_next_idx;
            r_addr  <= w_next_idx;
            r_state <= StRSetup;
          end
        end
        StAck: begin
          if (w_tmo_hit) begin
            r_end_ack <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= StFin;
          end else if (!fpu_cmd_end) begin
            r_end_ack <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b0;
            r_result  <= r_shadow;
            r_state   <= StFin;
          end
        end
        StFin: begin
          r_ready <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ready       = r_ready;
  assign done        = r_done;
  assign err         = r_err;
  assign result      = r_result;
  assign fpu_cs      = r_cs;
  assign fpu_rd      = r_rd;
  assign fpu_wr      = r_wr;
  assign fpu_addr    = r_addr;
  assign fpu_dout    = r_dout;
  assign fpu_end_ack = r_end_ack;

endmodule

// File: tb/tb_fpu_host_ctrl.sv
// Directed, table-driven bench for fpu_host_ctrl with a small FPU bus model; a second
// instance runs with STROBE_CYCLES=3 to check strobe width and phase length.
module tb_fpu_host_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start, start3;
  logic [31:0] op_a, op_b;
  logic [7:0]  opcode;
  logic        ready, done, err, fpu_cs, fpu_rd, fpu_wr, fpu_end_ack, cmd_end;
  logic [31:0] result;
  logic [3:0]  fpu_addr;
  logic [7:0]  fpu_dout, fpu_din;
  logic [31:0] cur_rdata;

  logic        ready3, done3, err3, cs3, rd3, wr3, end_ack3, cmd_end3;
  logic [31:0] result3;
  logic [3:0]  addr3;
  logic [7:0]  dout3;

  always #5 clk = ~clk;

  fpu_host_ctrl #(.STROBE_CYCLES(1), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .op_a(op_a), .op_b(op_b), .opcode(opcode),
    .ready(ready), .done(done), .err(err), .result(result), .fpu_cs(fpu_cs),
    .fpu_rd(fpu_rd), .fpu_wr(fpu_wr), .fpu_addr(fpu_addr), .fpu_dout(fpu_dout),
    .fpu_din(fpu_din), .fpu_cmd_end(cmd_end), .fpu_end_ack(fpu_end_ack)
  );

  fpu_host_ctrl #(.STROBE_CYCLES(3), .TIMEOUT_CYCLES(64)) dut3 (
    .clk(clk), .arst_n(arst_n), .start(start3), .op_a(32'h0), .op_b(32'h0), .opcode(8'h0),
    .ready(ready3), .done(done3), .err(err3), .result(result3), .fpu_cs(cs3),
    .fpu_rd(rd3), .fpu_wr(wr3), .fpu_addr(addr3), .fpu_dout(dout3),
    .fpu_din(8'h5A), .fpu_cmd_end(cmd_end3), .fpu_end_ack(end_ack3)
  );

  // Second FPU model finishes instantly and drops cmd_end as soon as it is acknowledged.
  assign cmd_end3 = ~end_ack3;

  always_comb begin
    fpu_din = 8'h00;
    case (fpu_addr)
      4'd9:    fpu_din = cur_rdata[7:0];
      4'd10:   fpu_din = cur_rdata[15:8];
      4'd11:   fpu_din = cur_rdata[23:16];
      4'd12:   fpu_din = cur_rdata[31:24];
      default: fpu_din = 8'h00;
    endcase
  end

  typedef struct {
    logic [31:0] a, b;
    logic [7:0]  op;
    logic [71:0] w;      // expected bytes at addr 0..8, byte i at [8*i +: 8]
    logic [31:0] rdata, res;
    int          c, hold, lat;
    bit          busy;
  } vec_t;

  typedef struct {
    int cs_low, wph, wr_n, rd_n, wr_run, rd_run, wmin, wmax, rmin, rmax;
    int both, unstable, ack_hi, done_n;
    bit wdone, pcs, pwr, prd;
    logic [11:0] pad, la;
    logic [15:0][11:0] wlog;
  } mon_t;

  mon_t m, m3;
  vec_t vecs[4];
  int   n_chk = 0, n_pass = 0;
  logic [31:0] last_res;

  function automatic mon_t mon_new();
    mon_t r;
    r = '{default: 0};
    r.wmin = 99; r.rmin = 99;
    r.pcs = 1'b1; r.pwr = 1'b1; r.prd = 1'b1;
    return r;
  endfunction

  task automatic mon(inout mon_t s, input logic cs, input logic wr, input logic rd,
                     input logic ack, input logic dn, input logic [3:0] addr,
                     input logic [7:0] dout);
    logic [11:0] cur;
    cur = {addr, dout};
    if (cs && s.wr_n > 0) s.wdone = 1'b1;
    if (!cs) s.cs_low++;
    if (!cs && !s.wdone) s.wph++;
    if (!wr && !rd) s.both++;
    if (ack) s.ack_hi++;
    if (dn) s.done_n++;
    if (!wr) begin
      if (s.pwr) begin
        if (s.pcs || s.pad != cur) s.unstable++;
        if (s.wr_n < 16) s.wlog[s.wr_n] = cur;
        s.wr_n++; s.wr_run = 0; s.la = cur;
      end
      if (cur != s.la) s.unstable++;
      s.wr_run++;
    end else if (!s.pwr) begin
      if (s.wr_run < s.wmin) s.wmin = s.wr_run;
      if (s.wr_run > s.wmax) s.wmax = s.wr_run;
      if (cs || cur != s.la) s.unstable++;
    end
    if (!rd) begin
      if (s.prd) begin
        if (s.pcs || s.pad != cur) s.unstable++;
        s.rd_n++; s.rd_run = 0; s.la = cur;
      end
      if (cur != s.la) s.unstable++;
      s.rd_run++;
    end else if (!s.prd) begin
      if (s.rd_run < s.rmin) s.rmin = s.rd_run;
      if (s.rd_run > s.rmax) s.rmax = s.rd_run;
      if (cs || cur != s.la) s.unstable++;
    end
    s.pcs = cs; s.pwr = wr; s.prd = rd; s.pad = cur;
  endtask

  task automatic tick();
    @(negedge clk);
    mon(m, fpu_cs, fpu_wr, fpu_rd, fpu_end_ack, done, fpu_addr, fpu_dout);
    mon(m3, cs3, wr3, rd3, end_ack3, done3, addr3, dout3);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    m = mon_new();
    cur_rdata = v.rdata;
    op_a = v.a; op_b = v.b; opcode = v.op; start = 1'b1;
    tick();
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; opcode = 8'($urandom);
    chk("ready_busy", ready, 0);
    n = 0;
    while (m.wr_n < 9 && n < 100) begin tick(); n++; end
    chk("write_phase_bound", m.wr_n, 9);
    for (int i = 0; i < v.c; i++) begin
      tick();
      start = v.busy && (i == 3);
      if (start) op_a = 32'h3F800000;
    end
    start = 1'b0;
    cmd_end = 1'b1;
    n = 0;
    while (!fpu_end_ack && n < 100) begin tick(); n++; end
    chk("ack_latency", n, v.lat);
    for (int i = 0; i < v.hold; i++) tick();
    cmd_end = 1'b0;
    tick();
    chk("done_pulse", done, 1);
    chk("ack_fall", fpu_end_ack, 0);
    chk("result", result, v.res);
    chk("err_ok", err, 0);
    chk("ready_fin", ready, 0);
    tick();
    chk("done_single", done, 0);
    chk("ready_idle", ready, 1);
    tick(); tick();
    chk("wr_count", m.wr_n, 9);
    for (int i = 0; i < 9; i++) chk("wbyte", m.wlog[i], {4'(i), v.w[8*i +: 8]});
    chk("rd_count", m.rd_n, 4);
    chk("wr_width_min", m.wmin, 1);
    chk("wr_width_max", m.wmax, 1);
    chk("rd_width_min", m.rmin, 1);
    chk("rd_width_max", m.rmax, 1);
    chk("cs_low_cycles", m.cs_low, 39);
    chk("write_phase_len", m.wph, 27);
    chk("rd_wr_overlap", m.both, 0);
    chk("bus_stability", m.unstable, 0);
    chk("ack_high_cycles", m.ack_hi, v.hold + 1);
    chk("done_count", m.done_n, 1);
    last_res = v.res;
  endtask

  initial begin
    int n;
    vecs[0] = '{a: 32'h43A9AB64, b: 32'hC479FFF0, op: 8'h05, w: 72'h05_C479FFF0_43A9AB64,
                rdata: 32'hC4252A3D, res: 32'hC4252A3D, c: 20, hold: 5, lat: 13, busy: 1'b1};
    vecs[1] = '{a: 32'h3F800000, b: 32'h40000000, op: 8'h01, w: 72'h01_40000000_3F800000,
                rdata: 32'h40400000, res: 32'h40400000, c: 0, hold: 0, lat: 15, busy: 1'b0};
    vecs[2] = '{a: 32'hFFFFFFFF, b: 32'h00000000, op: 8'hFF, w: 72'hFF_00000000_FFFFFFFF,
                rdata: 32'h00000000, res: 32'h00000000, c: 5, hold: 1, lat: 13, busy: 1'b0};
    vecs[3] = '{a: 32'h12345678, b: 32'h9ABCDEF0, op: 8'h0A, w: 72'h0A_9ABCDEF0_12345678,
                rdata: 32'hDEADBEEF, res: 32'hDEADBEEF, c: 2, hold: 2, lat: 13, busy: 1'b0};
    m = mon_new(); m3 = mon_new();
    arst_n = 1'b0; start = 1'b0; start3 = 1'b0; cmd_end = 1'b0;
    op_a = 32'h0; op_b = 32'h0; opcode = 8'h0; cur_rdata = 32'h0; last_res = 32'h0;
    tick();
    chk("rst_ready", ready, 1);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_result", result, 0);
    chk("rst_strobes", {fpu_cs, fpu_rd, fpu_wr}, 3'b111);
    chk("rst_addr_dout", {fpu_addr, fpu_dout}, 0);
    chk("rst_end_ack", fpu_end_ack, 0);
    arst_n = 1'b1;
    tick(); tick();

    for (int k = 0; k < 4; k++) run_txn(vecs[k]);

    // Slow-strobe instance.
    m3 = mon_new();
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n = 0;
    while (!done3 && n < 300) begin tick(); n++; end
    chk("s3_done", done3, 1);
    chk("s3_result", result3, 32'h5A5A5A5A);
    chk("s3_err", err3, 0);
    tick(); tick();
    chk("s3_write_phase_len", m3.wph, 45);
    chk("s3_cs_low_cycles", m3.cs_low, 65);
    chk("s3_wr_count", m3.wr_n, 9);
    chk("s3_rd_count", m3.rd_n, 4);
    chk("s3_wr_width", {m3.wmin, m3.wmax}, {32'd3, 32'd3});
    chk("s3_rd_width", {m3.rmin, m3.rmax}, {32'd3, 32'd3});
    chk("s3_overlap_stability", {m3.both, m3.unstable}, 0);
    chk("s3_ready", ready3, 1);

`ifdef FPU_HOST_TIMEOUT_EN
    m = mon_new();
    cur_rdata = 32'h11111111;
    op_a = vecs[0].a; op_b = vecs[0].b; opcode = vecs[0].op; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!m.wdone && n < 100) begin tick(); n++; end
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    chk("tmo_cycles", n, 64);
    chk("tmo_err", err, 1);
    chk("tmo_result_kept", result, last_res);
    chk("tmo_cs", fpu_cs, 1);
    chk("tmo_end_ack", fpu_end_ack, 0);
    tick();
    chk("tmo_ready", ready, 1);
    chk("tmo_done_single", done, 0);
`endif

    // Reset during the byte-3 write strobe.
    m = mon_new();
    op_a = vecs[1].a; op_b = vecs[1].b; opcode = vecs[1].op; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(m.wr_n == 4 && !fpu_wr) && n < 100) begin tick(); n++; end
    chk("rst_mid_reached", {m.wr_n, fpu_addr}, {32'd4, 4'd3});
    arst_n = 1'b0;
    #1;
    chk("rst_mid_strobes", {fpu_cs, fpu_wr, fpu_rd}, 3'b111);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_ready", ready, 1);
    chk("rst_mid_done", {done, fpu_end_ack}, 0);
    tick(); tick();
    arst_n = 1'b1;
    tick();
    chk("rst_rel_ready", ready, 1);
    run_txn(vecs[3]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
